dense_mac_layer: RTL and testbench
==================================

// Module: dense_mac_layer
// PURPOSE
//  Streaming fully-connected layer engine. Receives a pixel stream (x_*), a matching wide weight stream (w_*)
//  and one bias beat (b_*) from the memory manager, accumulates NUM_NEURONS dot products in parallel, then emits
//  one quantized 4-bit activation per neuron on a_*. Sits between the BRAM-feeding memory manager and the next layer.
// PARAMETERS
//  INPUT_SIZE   784  x/w beats per inference (input vector length)
//  NUM_NEURONS  160  neurons accumulated in parallel
//  X_W          12   x_tdata width, unsigned pixel
//  W_W          4    per-neuron weight width, signed two's complement
//  B_W          4    per-neuron bias width, signed two's complement
//  ACC_W        32   per-neuron accumulator width, signed
//  BIAS_SHIFT   0    bias left-shift applied when loading accumulators
//  OUT_SHIFT    2    arithmetic right-shift applied before output saturation
// PORTS
//  CLK        in   1               clock
//  RSTN       in   1               synchronous active-low reset
//  configure  in   3               3'b001 start, 3'b100 abort, others no-op
//  status     out  2               00 IDLE, 01 LOAD_BIAS/ACCUM, 10 DRAIN, 11 unused
//  b_tdata    in   NUM_NEURONS*B_W biases, neuron n at [n*B_W +: B_W]
//  b_tvalid   in   1               bias beat valid
//  b_tready   out  1               bias beat accepted
//  x_tdata    in   X_W             input pixel
//  x_tvalid   in   1               pixel valid
//  x_tready   out  1               pixel accepted (joined with w)
//  w_tdata    in   NUM_NEURONS*W_W weights for current pixel, neuron n at [n*W_W +: W_W]
//  w_tvalid   in   1               weight beat valid
//  w_tready   out  1               weight beat accepted (joined with x)
//  a_tdata    out  4               activation, unsigned 0..15
//  a_tvalid   out  1               activation valid
//  a_tready   in   1               downstream accepts
//  a_tlast    out  1               high on neuron NUM_NEURONS-1 beat
// BEHAVIOUR
//  Reset: RSTN sampled on CLK edge only. State IDLE, status=00, b/x/w_tready=0, a_tvalid=0, a_tlast=0,
//   a_tdata=0, beat counter=0, neuron index=0, accumulators=0.
//  FSM IDLE -> LOAD_BIAS -> ACCUM -> DRAIN -> IDLE.
//  IDLE: configure==001 -> LOAD_BIAS next cycle. All readys 0.
//  LOAD_BIAS: b_tready=1. On b_tvalid: acc[n] <= sext(bias[n]) << BIAS_SHIFT for all n, beat counter <= 0,
//   -> ACCUM. Exactly one bias beat per inference.
//  ACCUM: x_tready = w_tready = x_tvalid & w_tvalid (joined handshake; neither stream consumed alone).
//   On transfer: acc[n] <= acc[n] + $signed({1'b0,x}) * $signed(w[n]) for all n, counter++.
//   Product is X_W+W_W+1 bits, sign-extended to ACC_W; accumulator wraps mod 2^ACC_W (no saturation).
//   Transfer with counter==INPUT_SIZE-1 -> DRAIN, neuron index <= 0. Stalls indefinitely without valid.
//  DRAIN: a_tvalid=1; a_tdata = sat4(relu(acc[idx]) >>> OUT_SHIFT): negative -> 0, >15 -> 15.
//   a_tlast = (idx==NUM_NEURONS-1). a_tdata/a_tlast driven from registered state only; stable while a_tready=0.
//   On a_tvalid & a_tready: idx++; on last beat -> IDLE, a_tvalid=0 next cycle.
//  Output latency: first activation valid the cycle after the final x/w transfer.
//  configure==001 outside IDLE: ignored. configure==100 in any state: -> IDLE next cycle, counters cleared,
//   readys and a_tvalid dropped; accumulators need not be cleared (reloaded by bias).
//  Simultaneous abort and transfer in same cycle: abort wins, transfer still counts as handshaked upstream
//   (data discarded).
//  status: 00 in IDLE, 01 in LOAD_BIAS/ACCUM, 10 in DRAIN; registered with state.
// TESTING (bench: NUM_NEURONS=4, INPUT_SIZE=3, OUT_SHIFT=2, BIAS_SHIFT=0)
//  Basic: bias {2,-1,0,1} (n3..n0), x=10,20,30, weights n0{1,1,1} n1{1,-1,0} n2{0,0,1} n3{0,1,0}
//   -> a_tdata 15,0,7,5 with a_tlast on 4th beat; status 00->01->10->00.
//  Backpressure: random x/w valid gaps and a_tready low 3 cycles per beat -> same outputs, a_tdata held stable,
//   x_tready never high without both valids.
//  Saturation/ReLU: x=4095 all beats, all weights -8, bias 0 -> all outputs 0; weights +7 -> all outputs 15.
//  Abort: configure=100 after 2nd x/w beat -> status 00 next cycle, readys 0; restart with basic stimulus
//   -> 15,0,7,5.
//  Reset mid-DRAIN: RSTN=0 one cycle while a_tvalid=1 -> all outputs at reset values next edge, no further beats.
//  Back-to-back: two inferences with start held at 001 -> second starts only after first a_tlast handshake.

Source files
------------

// File: rtl/dense_mac_layer.sv
// Streaming fully-connected layer: one bias beat, INPUT_SIZE joined x/w beats, then NUM_NEURONS
// quantized 4-bit activations. First activation is valid the cycle after the final x/w transfer.
module dense_mac_layer #(
  parameter int INPUT_SIZE  = 784,
  parameter int NUM_NEURONS = 160,
  parameter int X_W         = 12,
  parameter int W_W         = 4,
  parameter int B_W         = 4,
  parameter int ACC_W       = 32,
  parameter int BIAS_SHIFT  = 0,
  parameter int OUT_SHIFT   = 2
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic [2:0]                 configure,
  output logic [1:0]                 status,
  input  logic [NUM_NEURONS*B_W-1:0] b_tdata,
  input  logic                       b_tvalid,
  output logic                       b_tready,
  input  logic [X_W-1:0]             x_tdata,
  input  logic                       x_tvalid,
  output logic                       x_tready,
  input  logic [NUM_NEURONS*W_W-1:0] w_tdata,
  input  logic                       w_tvalid,
  output logic                       w_tready,
  output logic [3:0]                 a_tdata,
  output logic                       a_tvalid,
  input  logic                       a_tready,
  output logic                       a_tlast
);

  localparam int P_W   = X_W + W_W + 1;
  localparam int CNT_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_BIAS = 2'd1,
    S_ACCUM     = 2'd2,
    S_DRAIN     = 2'd3
  } state_t;

  state_t            state_q;
  logic [1:0]        status_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ACC_W-1:0]  acc_q [NUM_NEURONS];

  logic [ACC_W-1:0]  bias_ext [NUM_NEURONS];
  logic [ACC_W-1:0]  prod_ext [NUM_NEURONS];

  logic start, abort, xw_xfer, cnt_last, idx_last;

  assign start    = (configure == 3'b001);
  assign abort    = (configure == 3'b100);
  assign cnt_last = (cnt_q == CNT_W'(INPUT_SIZE - 1));
  assign idx_last = (idx_q == IDX_W'(NUM_NEURONS - 1));

  // Joined handshake: neither stream is consumed unless both are valid.
  assign xw_xfer  = (state_q == S_ACCUM) && x_tvalid && w_tvalid;
  assign x_tready = xw_xfer;
  assign w_tready = xw_xfer;
  assign b_tready = (state_q == S_LOAD_BIAS);
  assign status   = status_q;

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    logic signed [B_W-1:0] bias;
    logic signed [W_W-1:0] wt;
    logic signed [P_W-1:0] prod;
    assign bias        = b_tdata[n*B_W +: B_W];
    assign wt          = w_tdata[n*W_W +: W_W];
    assign prod        = P_W'($signed({1'b0, x_tdata})) * P_W'(wt);
    assign bias_ext[n] = {{(ACC_W-B_W){bias[B_W-1]}}, bias} << BIAS_SHIFT;
    assign prod_ext[n] = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
  end

  // Activation: ReLU, arithmetic shift, saturate to 0..15; held while a_tready is low.
  logic [ACC_W-1:0] sel_acc, shifted;
  logic [3:0]       act;
  assign sel_acc = acc_q[idx_q];
  assign shifted = sel_acc >> OUT_SHIFT;
  always_comb begin
    act = shifted[3:0];
    if (sel_acc[ACC_W-1])          act = 4'd0;
    else if (|shifted[ACC_W-1:4])  act = 4'd15;
  end

  assign a_tvalid = (state_q == S_DRAIN);
  assign a_tdata  = a_tvalid ? act : 4'd0;
  assign a_tlast  = a_tvalid && idx_last;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q  <= S_IDLE;
      status_q <= 2'b00;
      cnt_q    <= '0;
      idx_q    <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) acc_q[n] <= '0;
    end else if (abort) begin
      state_q  <= S_IDLE;
      status_q <= 2'b00;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_LOAD_BIAS;
            status_q <= 2'b01;
          end
        end
        S_LOAD_BIAS: begin
          if (b_tvalid) begin
            for (int n = 0; n < NUM_NEURONS; n++) acc_q[n] <= bias_ext[n];
            cnt_q   <= '0;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (xw_xfer) begin
            for (int n = 0; n < NUM_NEURONS; n++) acc_q[n] <= acc_q[n] + prod_ext[n];
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_last) begin
              state_q  <= S_DRAIN;
              status_q <= 2'b10;
              idx_q    <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (a_tready) begin
            if (idx_last) begin
              state_q  <= S_IDLE;
              status_q <= 2'b00;
              idx_q    <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          status_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_mac_layer.sv
// Directed bench for dense_mac_layer with 4 neurons and 3-beat input vectors.
module tb_dense_mac_layer;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [2:0]  configure;
  logic [1:0]  status;
  logic [15:0] b_tdata;
  logic        b_tvalid, b_tready;
  logic [11:0] x_tdata;
  logic        x_tvalid, x_tready;
  logic [15:0] w_tdata;
  logic        w_tvalid, w_tready;
  logic [3:0]  a_tdata;
  logic        a_tvalid, a_tready, a_tlast;

  int checks = 0;
  int errors = 0;

  dense_mac_layer #(
    .INPUT_SIZE(3), .NUM_NEURONS(4), .X_W(12), .W_W(4), .B_W(4),
    .ACC_W(32), .BIAS_SHIFT(0), .OUT_SHIFT(2)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .configure(configure), .status(status),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready),
    .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
    .w_tdata(w_tdata), .w_tvalid(w_tvalid), .w_tready(w_tready),
    .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready), .a_tlast(a_tlast)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Basic vector set: bias {2,-1,0,1} (n3..n0), weights per beat packed n3..n0.
  localparam logic [15:0] BASIC_B  = 16'h2F01;
  localparam logic [15:0] BASIC_W0 = 16'h0011;
  localparam logic [15:0] BASIC_W1 = 16'h10F1;
  localparam logic [15:0] BASIC_W2 = 16'h0101;
  localparam logic [15:0] BASIC_A  = 16'h570F; // n3..n0 = 5,7,0,15

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bias(input logic [15:0] b);
    b_tdata  = b;
    b_tvalid = 1'b1;
    #1;
    check("b_tready_in_load", {31'd0, b_tready}, 32'd1);
    tick;
    b_tvalid = 1'b0;
  endtask

  task automatic send_xw(input logic [11:0] x, input logic [15:0] w, input int gap);
    x_tdata = x;
    w_tdata = w;
    for (int g = 0; g < gap; g++) begin
      x_tvalid = (g % 2 == 1);
      w_tvalid = (g % 3 == 2);
      if (x_tvalid && w_tvalid) w_tvalid = 1'b0;
      #1;
      check("x_tready_no_join", {31'd0, x_tready}, 32'd0);
      check("w_tready_no_join", {31'd0, w_tready}, 32'd0);
      tick;
    end
    x_tvalid = 1'b1;
    w_tvalid = 1'b1;
    #1;
    check("x_tready_joined", {31'd0, x_tready}, 32'd1);
    tick;
    x_tvalid = 1'b0;
    w_tvalid = 1'b0;
  endtask

  task automatic send_basic_xw(input int gap);
    send_xw(12'd10, BASIC_W0, gap);
    send_xw(12'd20, BASIC_W1, gap);
    send_xw(12'd30, BASIC_W2, gap);
  endtask

  task automatic drain(input logic [15:0] expv, input int stall);
    logic [15:0] ev;
    ev = expv;
    for (int i = 0; i < 4; i++) begin
      check("a_tvalid_beat", {31'd0, a_tvalid}, 32'd1);
      check("a_tdata_beat", {28'd0, a_tdata}, {28'd0, ev[i*4 +: 4]});
      check("a_tlast_beat", {31'd0, a_tlast}, {31'd0, (i == 3)});
      for (int s = 0; s < stall; s++) begin
        a_tready = 1'b0;
        tick;
        check("a_tdata_held", {28'd0, a_tdata}, {28'd0, ev[i*4 +: 4]});
        check("a_tvalid_held", {31'd0, a_tvalid}, 32'd1);
      end
      a_tready = 1'b1;
      tick;
      a_tready = 1'b0;
    end
    check("a_tvalid_after_last", {31'd0, a_tvalid}, 32'd0);
    check("status_idle_after_drain", {30'd0, status}, 32'd0);
  endtask

  task automatic start_inference;
    configure = 3'b001;
    tick;
    configure = 3'b000;
    check("status_load", {30'd0, status}, 32'd1);
  endtask

  initial begin
    RSTN = 1'b0; configure = 3'b000;
    b_tdata = '0; b_tvalid = 1'b0;
    x_tdata = '0; x_tvalid = 1'b0;
    w_tdata = '0; w_tvalid = 1'b0;
    a_tready = 1'b0;
    tick; tick;
    RSTN = 1'b1;
    tick;

    // Reset state
    check("rst_status", {30'd0, status}, 32'd0);
    check("rst_b_tready", {31'd0, b_tready}, 32'd0);
    check("rst_x_tready", {31'd0, x_tready}, 32'd0);
    check("rst_a_tvalid", {31'd0, a_tvalid}, 32'd0);
    check("rst_a_tlast", {31'd0, a_tlast}, 32'd0);
    check("rst_a_tdata", {28'd0, a_tdata}, 32'd0);

    // Basic inference with latency and status sequence
    start_inference;
    send_bias(BASIC_B);
    check("status_accum", {30'd0, status}, 32'd1);
    send_basic_xw(0);
    check("status_drain", {30'd0, status}, 32'd2);
    drain(BASIC_A, 0);

    // Backpressure on both sides
    start_inference;
    send_bias(BASIC_B);
    send_xw(12'd10, BASIC_W0, 3);
    x_tvalid = 1'b1; w_tvalid = 1'b0; #1;
    check("x_only_no_ready", {31'd0, x_tready}, 32'd0);
    tick;
    x_tvalid = 1'b0;
    send_xw(12'd20, BASIC_W1, $urandom_range(1, 4));
    send_xw(12'd30, BASIC_W2, $urandom_range(1, 4));
    drain(BASIC_A, 3);

    // Saturation / ReLU
    start_inference;
    send_bias(16'h0000);
    for (int i = 0; i < 3; i++) send_xw(12'd4095, 16'h8888, 0);
    drain(16'h0000, 0);
    start_inference;
    send_bias(16'h0000);
    for (int i = 0; i < 3; i++) send_xw(12'd4095, 16'h7777, 0);
    drain(16'hFFFF, 0);

    // Abort after second beat, then restart
    start_inference;
    send_bias(BASIC_B);
    send_xw(12'd10, BASIC_W0, 0);
    send_xw(12'd20, BASIC_W1, 0);
    configure = 3'b100;
    tick;
    configure = 3'b000;
    x_tvalid = 1'b1; w_tvalid = 1'b1; b_tvalid = 1'b1; #1;
    check("abort_status", {30'd0, status}, 32'd0);
    check("abort_x_tready", {31'd0, x_tready}, 32'd0);
    check("abort_b_tready", {31'd0, b_tready}, 32'd0);
    check("abort_a_tvalid", {31'd0, a_tvalid}, 32'd0);
    x_tvalid = 1'b0; w_tvalid = 1'b0; b_tvalid = 1'b0;
    tick;
    start_inference;
    send_bias(BASIC_B);
    send_basic_xw(0);
    drain(BASIC_A, 0);

    // Reset mid-drain
    start_inference;
    send_bias(BASIC_B);
    send_basic_xw(0);
    check("pre_rst_a_tvalid", {31'd0, a_tvalid}, 32'd1);
    a_tready = 1'b1;
    tick;
    a_tready = 1'b0;
    RSTN = 1'b0;
    tick;
    RSTN = 1'b1;
    check("mid_rst_a_tvalid", {31'd0, a_tvalid}, 32'd0);
    check("mid_rst_a_tlast", {31'd0, a_tlast}, 32'd0);
    check("mid_rst_a_tdata", {28'd0, a_tdata}, 32'd0);
    check("mid_rst_status", {30'd0, status}, 32'd0);
    check("mid_rst_b_tready", {31'd0, b_tready}, 32'd0);
    a_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("post_rst_no_beat", {31'd0, a_tvalid}, 32'd0);
    end
    a_tready = 1'b0;

    // Back-to-back with start held
    configure = 3'b001;
    tick;
    check("b2b_status_load1", {30'd0, status}, 32'd1);
    send_bias(BASIC_B);
    send_basic_xw(0);
    for (int i = 0; i < 4; i++) begin
      check("b2b_drain_status", {30'd0, status}, 32'd2);
      check("b2b_a_tdata", {28'd0, a_tdata}, {28'd0, 4'(BASIC_A >> (i*4))});
      a_tready = 1'b1;
      tick;
    end
    a_tready = 1'b0;
    check("b2b_idle_after_last", {30'd0, status}, 32'd0);
    tick;
    check("b2b_status_load2", {30'd0, status}, 32'd1);
    configure = 3'b000;
    send_bias(BASIC_B);
    send_basic_xw(1);
    drain(BASIC_A, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
